// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: reset/run sequencer for the 4-stage core.
// Optional PC-change trace: define RUN_CTRL_PC_TRACE_EN.
module pipeline_run_controller #(
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 9,
  parameter int HALT_STABLE = 3,
  parameter int CNT_W       = 16,
  parameter int PC_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W-1:0]  pc_in,
  output logic             core_reset,
  output logic             core_run,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [PC_W-1:0]  final_pc,
  output logic [CNT_W-1:0] pc_changes
);

  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(HALT_STABLE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [HW-1:0]   hold_q;
  logic [HW-1:0]   hold_d;
  logic [SW-1:0]   stab_q;
  logic [SW-1:0]   stab_d;
  logic [SW-1:0]   stab_nx;
  logic [PC_W-1:0] prev_q;
  logic [PC_W-1:0] prev_d;
  logic            have_q;
  logic            have_d;
  logic            same;
  logic            hit_halt;
  logic            hit_to;
  logic            halted_d;
  logic            timeout_d;
  logic [CNT_W-1:0] cc_d;
  logic [CNT_W-1:0] cc_nx;
  logic [PC_W-1:0] fpc_d;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, counters and run-exit flags
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stab_d    = stab_q;
    prev_d    = prev_q;
    have_d    = have_q;
    halted_d  = halted;
    timeout_d = timeout;
    cc_d      = cycle_count;
    fpc_d     = final_pc;
    same      = have_q && (pc_in == prev_q);
    stab_nx   = same ? stab_q + 1'b1 : '0;
    cc_nx     = (&cycle_count) ? cycle_count
                               : cycle_count + 1'b1;
    hit_halt  = (stab_nx == SW'(HALT_STABLE));
    hit_to    = (MAX_CYCLES != 0) &&
                (cc_nx == CNT_W'(MAX_CYCLES));
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_HOLD;
          hold_d    = '0;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
          cc_d      = '0;
          fpc_d     = '0;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d   = S_IDLE;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HW'(RST_CYCLES - 1)) begin
            state_d = S_RUN;
            stab_d  = '0;
            have_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        cc_d   = cc_nx;
        stab_d = stab_nx;
        prev_d = pc_in;
        have_d = 1'b1;
        if (abort) begin
          state_d   = S_IDLE;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
        end else if (hit_halt) begin
          state_d  = S_DONE;
          halted_d = 1'b1;
          fpc_d    = pc_in;
        end else if (hit_to) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          fpc_d     = pc_in;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // datapath registers and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      stab_q      <= '0;
      prev_q      <= '0;
      have_q      <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      final_pc    <= '0;
      core_reset  <= 1'b1;
      core_run    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      stab_q      <= stab_d;
      prev_q      <= prev_d;
      have_q      <= have_d;
      halted      <= halted_d;
      timeout     <= timeout_d;
      cycle_count <= cc_d;
      final_pc    <= fpc_d;
      core_reset  <= (state_d != S_RUN);
      core_run    <= (state_d == S_RUN);
      busy        <= (state_d == S_HOLD) ||
                     (state_d == S_RUN);
      done        <= (state_d == S_DONE);
    end
  end

`ifdef RUN_CTRL_PC_TRACE_EN
  logic go;
  logic chg;

  assign go  = ((state_q == S_IDLE) ||
                (state_q == S_DONE)) && start;
  assign chg = (state_q == S_RUN) && have_q &&
               (pc_in != prev_q);

  // saturating count of PC changes during RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_changes <= '0;
    end else if (go) begin
      pc_changes <= '0;
    end else if (chg && !(&pc_changes)) begin
      pc_changes <= pc_changes + 1'b1;
    end
  end
`else
  assign pc_changes = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller: three configurations under shared
// random stimulus, checked against a run-history reference model.
module tb_pipeline_run_controller;

`ifdef RUN_CTRL_PC_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  localparam int RSTC = 2;
  localparam int HS   = 3;
  localparam int P_IDLE = 0;
  localparam int P_HOLD = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  typedef struct {
    bit          h;
    bit          t;
    int unsigned cc;
    int unsigned fp;
    int unsigned ch;
  } rec_t;

  int maxc [3] = '{9, 4, 0};
  int cmax [3] = '{65535, 65535, 15};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st = 1'b0;
  logic        ab = 1'b0;
  logic [31:0] pc = '0;

  logic        creset [3];
  logic        crun [3];
  logic        bsy [3];
  logic        dn [3];
  logic        hl [3];
  logic        tmo [3];
  logic [31:0] fp [3];
  logic [31:0] ccw [3];
  logic [31:0] pchw [3];
  logic [15:0] cc0, cc1, pch0, pch1;
  logic [3:0]  cc2, pch2;

  assign ccw[0]  = {16'b0, cc0};
  assign ccw[1]  = {16'b0, cc1};
  assign ccw[2]  = {28'b0, cc2};
  assign pchw[0] = {16'b0, pch0};
  assign pchw[1] = {16'b0, pch1};
  assign pchw[2] = {28'b0, pch2};

  pipeline_run_controller #(
    .RST_CYCLES(2), .MAX_CYCLES(9), .HALT_STABLE(3),
    .CNT_W(16), .PC_W(32)
  ) u0 (
    .clk(clk), .reset(rst), .start(st), .abort(ab),
    .pc_in(pc), .core_reset(creset[0]), .core_run(crun[0]),
    .busy(bsy[0]), .done(dn[0]), .halted(hl[0]),
    .timeout(tmo[0]), .cycle_count(cc0), .final_pc(fp[0]),
    .pc_changes(pch0)
  );

  pipeline_run_controller #(
    .RST_CYCLES(2), .MAX_CYCLES(4), .HALT_STABLE(3),
    .CNT_W(16), .PC_W(32)
  ) u1 (
    .clk(clk), .reset(rst), .start(st), .abort(ab),
    .pc_in(pc), .core_reset(creset[1]), .core_run(crun[1]),
    .busy(bsy[1]), .done(dn[1]), .halted(hl[1]),
    .timeout(tmo[1]), .cycle_count(cc1), .final_pc(fp[1]),
    .pc_changes(pch1)
  );

  pipeline_run_controller #(
    .RST_CYCLES(2), .MAX_CYCLES(0), .HALT_STABLE(3),
    .CNT_W(4), .PC_W(32)
  ) u2 (
    .clk(clk), .reset(rst), .start(st), .abort(ab),
    .pc_in(pc), .core_reset(creset[2]), .core_run(crun[2]),
    .busy(bsy[2]), .done(dn[2]), .halted(hl[2]),
    .timeout(tmo[2]), .cycle_count(cc2), .final_pc(fp[2]),
    .pc_changes(pch2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit armed = 1'b0;

  int          ph [3] = '{P_IDLE, P_IDLE, P_IDLE};
  int          hc [3];
  bit          mh [3];
  bit          mt [3];
  int unsigned mcc [3];
  int unsigned mfp [3];
  int unsigned mch [3];
  int          rn [3];
  int unsigned runpc [3][4096];
  bit          pdn [3];
  bit          pbz [3];

  rec_t q0[$];
  rec_t q1[$];
  rec_t q2[$];

  function automatic void qpush(int i, rec_t r);
    case (i)
      0: q0.push_back(r);
      1: q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endfunction

  function automatic int qsize(int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic rec_t qpop(int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void chk(string nm, int i,
                              logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d got=%0h want=%0h t=%0t",
               nm, i, act, exp, $time);
    end
  endfunction

  function automatic int unsigned umin(int unsigned a,
                                       int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic void clear_run(int i);
    mh[i]  = 1'b0;
    mt[i]  = 1'b0;
    mcc[i] = 0;
    mfp[i] = 0;
    mch[i] = 0;
    rn[i]  = 0;
  endfunction

  // reference model: a run is the list of PCs seen while running;
  // counts and the halt test are read off that history
  function automatic void step(int i);
    int k;
    int c;
    rec_t r;
    if (rst) begin
      if (ph[i] == P_HOLD || ph[i] == P_RUN) begin
        r = '{1'b0, 1'b0, 0, 0, 0};
        qpush(i, r);
      end
      ph[i] = P_IDLE;
      clear_run(i);
    end else if ((ph[i] == P_IDLE || ph[i] == P_DONE) && st) begin
      ph[i] = P_HOLD;
      hc[i] = 0;
      clear_run(i);
    end else if (ph[i] == P_HOLD) begin
      if (ab) begin
        ph[i] = P_IDLE;
        r = '{1'b0, 1'b0, mcc[i], mfp[i], mch[i]};
        qpush(i, r);
      end else begin
        hc[i]++;
        if (hc[i] == RSTC) ph[i] = P_RUN;
      end
    end else if (ph[i] == P_RUN) begin
      if (rn[i] < 4096) begin
        runpc[i][rn[i]] = pc;
        rn[i]++;
      end
      mcc[i] = umin(rn[i], cmax[i]);
      k = 0;
      for (int j = rn[i] - 1;
           j > 0 && runpc[i][j] == runpc[i][j-1]; j--)
        k++;
      c = 0;
      for (int j = 1; j < rn[i]; j++)
        if (runpc[i][j] != runpc[i][j-1]) c++;
      mch[i] = umin(c, cmax[i]);
      if (ab) begin
        ph[i] = P_IDLE;
        r = '{1'b0, 1'b0, mcc[i], mfp[i], mch[i]};
        qpush(i, r);
      end else if (k >= HS) begin
        ph[i]  = P_DONE;
        mh[i]  = 1'b1;
        mfp[i] = pc;
        r = '{1'b1, 1'b0, mcc[i], mfp[i], mch[i]};
        qpush(i, r);
      end else if (maxc[i] != 0 && mcc[i] == maxc[i]) begin
        ph[i]  = P_DONE;
        mt[i]  = 1'b1;
        mfp[i] = pc;
        r = '{1'b0, 1'b1, mcc[i], mfp[i], mch[i]};
        qpush(i, r);
      end
    end
  endfunction

  // advance the model on every clock edge
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) step(i);
  end

  // monitor: per-cycle status plus scoreboard pops at run end
  always @(negedge clk) begin
    rec_t r;
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        chk("core_reset", i, 32'(creset[i]),
            32'(ph[i] != P_RUN));
        chk("core_run", i, 32'(crun[i]), 32'(ph[i] == P_RUN));
        chk("busy", i, 32'(bsy[i]),
            32'(ph[i] == P_HOLD || ph[i] == P_RUN));
        chk("done", i, 32'(dn[i]), 32'(ph[i] == P_DONE));
        chk("halted", i, 32'(hl[i]), 32'(mh[i]));
        chk("timeout", i, 32'(tmo[i]), 32'(mt[i]));
        chk("cycle_count", i, ccw[i], mcc[i]);
        if ((dn[i] && !pdn[i]) ||
            (pbz[i] && !bsy[i] && !dn[i])) begin
          if (qsize(i) == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_end u%0d t=%0t",
                     i, $time);
          end else begin
            r = qpop(i);
            chk("end_halted", i, 32'(hl[i]), 32'(r.h));
            chk("end_timeout", i, 32'(tmo[i]), 32'(r.t));
            chk("end_cycles", i, ccw[i], r.cc);
            chk("end_final_pc", i, fp[i], r.fp);
            chk("end_pc_changes", i, pchw[i],
                TRACE ? r.ch : 32'd0);
          end
        end
        pdn[i] = dn[i];
        pbz[i] = bsy[i];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_const(logic [31:0] v, int n);
    pc = v;
    st = 1'b1;
    cyc();
    st = 1'b0;
    for (int j = 0; j < n; j++) cyc();
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    armed = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    run_const(32'h0, 12);
    run_const(32'h0, 12);

    pc = 32'h0;
    st = 1'b1;
    cyc();
    st = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      cyc();
      if (j >= 3 && j < 27) pc = pc + 32'd4;
      st = (j == 5);
    end

    pc = 32'h100;
    st = 1'b1;
    cyc();
    st = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      cyc();
      pc = pc + 32'd4;
      ab = (j == 3);
    end

    pc = 32'h200;
    st = 1'b1;
    cyc();
    st = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      cyc();
      pc = pc + 32'd4;
      rst = (j == 3);
    end

    st = 1'b1;
    cyc();
    st = 1'b0;
    ab = 1'b1;
    cyc();
    ab = 1'b1;
    st = 1'b1;
    cyc();
    ab = 1'b0;
    st = 1'b0;
    pc = 32'h40;
    for (int j = 0; j < 12; j++) cyc();

    for (int j = 0; j < 400; j++) begin
      st  = ($urandom_range(7) == 0);
      ab  = ($urandom_range(29) == 0);
      rst = ($urandom_range(199) == 0);
      if ($urandom_range(9) >= 6)
        pc = 32'($urandom_range(7)) * 32'd4;
      cyc();
    end

    st  = 1'b0;
    ab  = 1'b0;
    rst = 1'b0;
    for (int j = 0; j < 40; j++) cyc();

    for (int i = 0; i < 3; i++)
      chk("sb_drained", i, 32'(qsize(i)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
